// File: rtl/switch_debounce_if.sv
// Switch debouncer signal bundle: raw pad inputs in, debounced levels and
// edge pulses out. The debouncer sits on the slave side.
interface switch_debounce_if #(
  parameter int unsigned WIDTH = 8
);
  logic [WIDTH-1:0] switch_raw_i;
  logic [WIDTH-1:0] switch_o;
  logic [WIDTH-1:0] rise_o;
  logic [WIDTH-1:0] fall_o;
  logic             change_o;

  modport master (
    output switch_raw_i,
    input  switch_o,
    input  rise_o,
    input  fall_o,
    input  change_o
  );

  modport slave (
    input  switch_raw_i,
    output switch_o,
    output rise_o,
    output fall_o,
    output change_o
  );
endinterface

// File: rtl/switch_debounce.sv
// Per-bit slide-switch debouncer: 2-flop synchronizer followed by a stability
// counter. A level is accepted after STABLE_CYCLES consecutive clocks that
// differ from the debounced value; acceptance emits registered rise/fall
// pulses and an aggregate change pulse in the same cycle.
module switch_debounce #(
  parameter int unsigned WIDTH         = 8,
  parameter int unsigned STABLE_CYCLES = 500000,
  parameter int unsigned CNT_W         = 20
) (
  input  logic              wb_clk,
  input  logic              wb_rst_n,
  switch_debounce_if.slave  sw
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE_CYCLES - 1);

  logic [WIDTH-1:0] sync1_q;
  logic [WIDTH-1:0] sync2_q;
  logic [CNT_W-1:0] cnt_q [WIDTH];
  logic [CNT_W-1:0] cnt_d [WIDTH];
  logic [WIDTH-1:0] sw_q,   sw_d;
  logic [WIDTH-1:0] rise_q, rise_d;
  logic [WIDTH-1:0] fall_q, fall_d;
  logic             change_q, change_d;

  // Two-flop synchronizer for the asynchronous pad inputs, nothing between.
  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= sw.switch_raw_i;
      sync2_q <= sync1_q;
    end
  end

  // Per-bit stability count; any agreeing cycle restarts it, exact compare
  // on the last count accepts the new level and fires the edge pulses.
  always_comb begin
    cnt_d  = '{default: '0};
    sw_d   = sw_q;
    rise_d = '0;
    fall_d = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (sync2_q[i] != sw_q[i]) begin
        if (cnt_q[i] == LAST) begin
          sw_d[i]   = sync2_q[i];
          rise_d[i] = sync2_q[i];
          fall_d[i] = ~sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
    change_d = |(rise_d | fall_d);
  end

  // Counters, debounced levels and registered pulses.
  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      cnt_q    <= '{default: '0};
      sw_q     <= '0;
      rise_q   <= '0;
      fall_q   <= '0;
      change_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      sw_q     <= sw_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      change_q <= change_d;
    end
  end

  assign sw.switch_o = sw_q;
  assign sw.rise_o   = rise_q;
  assign sw.fall_o   = fall_q;
  assign sw.change_o = change_q;

endmodule
